l2_flush_ctrl: RTL and testbench

L2_FLUSH_CTRL -- requirements
Module: l2_flush_ctrl

---
 rtl/l2_flush_ctrl_if.sv | 56 +++++
 rtl/l2_flush_ctrl.sv | 149 ++++++++++++++
 tb/tb_l2_flush_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// l2_flush_ctrl_if
// Purpose : bundles the flush-request handshake, the state-array lookup port
//           and the eviction handshake used by the L2 flush walker.
// Modports:
//   master - the flush controller (drives ready/lookup/evict/inv/status)
//   slave  - the surrounding cache logic (drives request, stall, credits,
//            lookup data and eviction acceptance)
// Signals :
//   flush_req_valid/flush_req_ready  flush request handshake
//   stall                            freezes the walk (lookup and eviction)
//   reqs_cnt                         free request-buffer entries
//   lookup_en/set/way, lookup_state  state-array read, data one cycle later
//   evict_valid/ready/set/way/dirty  eviction request handshake
//   inv_en                           invalidate strobe for the current line
//   ongoing_flush, flush_done        flush status
// ---------------------------------------------------------------------------
interface l2_flush_ctrl_if #(
  parameter int L2_SETS   = 256,
  parameter int L2_WAYS   = 8,
  parameter int REQS_P1_W = 3
);
  localparam int SET_W = $clog2(L2_SETS);
  localparam int WAY_W = $clog2(L2_WAYS);

  logic                 flush_req_valid;
  logic                 flush_req_ready;
  logic                 stall;
  logic [REQS_P1_W-1:0] reqs_cnt;
  logic                 lookup_en;
  logic [SET_W-1:0]     lookup_set;
  logic [WAY_W-1:0]     lookup_way;
  logic [1:0]           lookup_state;
  logic                 evict_valid;
  logic                 evict_ready;
  logic [SET_W-1:0]     evict_set;
  logic [WAY_W-1:0]     evict_way;
  logic                 evict_dirty;
  logic                 inv_en;
  logic                 ongoing_flush;
  logic                 flush_done;

  modport master (
    input  flush_req_valid, stall, reqs_cnt, lookup_state, evict_ready,
    output flush_req_ready, lookup_en, lookup_set, lookup_way,
           evict_valid, evict_set, evict_way, evict_dirty,
           inv_en, ongoing_flush, flush_done
  );

  modport slave (
    output flush_req_valid, stall, reqs_cnt, lookup_state, evict_ready,
    input  flush_req_ready, lookup_en, lookup_set, lookup_way,
           evict_valid, evict_set, evict_way, evict_dirty,
           inv_en, ongoing_flush, flush_done
  );
endinterface

// File: rtl/l2_flush_ctrl.sv
// ---------------------------------------------------------------------------
// l2_flush_ctrl
// Purpose : walks every line of an L2 cache (set-major, way-minor), reads its
//           state, issues an eviction for every valid line (dirty when the
//           line is MODIFIED), invalidates it on eviction acceptance and
//           signals completion.
// Ports   :
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - l2_flush_ctrl_if.master (request, lookup, eviction, status)
// Parameters:
//   L2_SETS, L2_WAYS - power-of-two geometry (each at least 2)
//   REQS_P1_W        - width of the free request-buffer counter
// ---------------------------------------------------------------------------
module l2_flush_ctrl #(
  parameter int L2_SETS   = 256,
  parameter int L2_WAYS   = 8,
  parameter int REQS_P1_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  l2_flush_ctrl_if.master      bus
);
  localparam int SET_W = $clog2(L2_SETS);
  localparam int WAY_W = $clog2(L2_WAYS);

  localparam logic [SET_W:0] SET_ONE = 1;
  localparam logic [WAY_W:0] WAY_ONE = 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_EVICT  = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] ST_INVALID  = 2'd0;
  localparam logic [1:0] ST_MODIFIED = 2'd3;

  logic [2:0]     r_state;
  logic [2:0]     w_state_next;
  // Counters carry one extra bit: the way MSB flags a set boundary, the set
  // MSB flags that the last line has been processed.
  logic [SET_W:0] r_set;
  logic [SET_W:0] w_set_next;
  logic [SET_W:0] w_set_inc;
  logic [WAY_W:0] r_way;
  logic [WAY_W:0] w_way_next;
  logic [WAY_W:0] w_way_inc;
  logic           r_dirty;
  logic           w_dirty_next;
  // Keeps flush_req_ready low until the first clock after reset release.
  logic           r_out_en;

  logic           w_accept;
  logic           w_lookup_fire;
  logic           w_evict_ok;
  logic           w_evict_fire;

  always_comb begin
    w_way_inc     = r_way + WAY_ONE;
    w_set_inc     = r_set + SET_ONE;
    w_accept      = (r_state == S_IDLE) && r_out_en && bus.flush_req_valid;
    w_lookup_fire = (r_state == S_LOOKUP) && !bus.stall;
    // No request-buffer credit or a stall blocks the eviction request
    // entirely rather than letting it drop mid-handshake.
    w_evict_ok    = (r_state == S_EVICT) && (bus.reqs_cnt != '0) && !bus.stall;
    w_evict_fire  = w_evict_ok && bus.evict_ready;

    w_state_next  = r_state;
    w_set_next    = r_set;
    w_way_next    = r_way;
    w_dirty_next  = r_dirty;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_LOOKUP;
          w_set_next   = '0;
          w_way_next   = '0;
        end
      end
      S_LOOKUP: begin
        if (w_lookup_fire) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        // Capture dirtiness here so the eviction target stays stable for as
        // long as the eviction is back-pressured.
        w_dirty_next = (bus.lookup_state == ST_MODIFIED);
        w_state_next = (bus.lookup_state == ST_INVALID) ? S_NEXT : S_EVICT;
      end
      S_EVICT: begin
        if (w_evict_fire) begin
          w_state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_way_inc[WAY_W]) begin
          w_way_next   = '0;
          w_set_next   = w_set_inc;
          w_state_next = w_set_inc[SET_W] ? S_DONE : S_LOOKUP;
        end else begin
          w_way_next   = w_way_inc;
          w_state_next = S_LOOKUP;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_set    <= '0;
      r_way    <= '0;
      r_dirty  <= 1'b0;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_set    <= w_set_next;
      r_way    <= w_way_next;
      r_dirty  <= w_dirty_next;
      r_out_en <= 1'b1;
    end
  end

  // All strobes decode directly from the state register so an asynchronous
  // reset clears them in the same cycle.
  assign bus.flush_req_ready = (r_state == S_IDLE) && r_out_en;
  assign bus.lookup_en       = w_lookup_fire;
  assign bus.lookup_set      = r_set[SET_W-1:0];
  assign bus.lookup_way      = r_way[WAY_W-1:0];
  assign bus.evict_valid     = w_evict_ok;
  assign bus.evict_set       = r_set[SET_W-1:0];
  assign bus.evict_way       = r_way[WAY_W-1:0];
  assign bus.evict_dirty     = r_dirty;
  assign bus.inv_en          = w_evict_fire;
  assign bus.ongoing_flush   = (r_state == S_LOOKUP) || (r_state == S_CHECK) ||
                               (r_state == S_EVICT)  || (r_state == S_NEXT);
  assign bus.flush_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_l2_flush_ctrl.sv
module tb_l2_flush_ctrl;
  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int RW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_flush_ctrl_if #(.L2_SETS(SETS), .L2_WAYS(WAYS), .REQS_P1_W(RW)) bus ();

  l2_flush_ctrl #(.L2_SETS(SETS), .L2_WAYS(WAYS), .REQS_P1_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Line-state array model: read data appears one cycle after lookup_en.
  logic [1:0] mem [SETS][WAYS];
  always @(posedge clk) begin
    if (bus.lookup_en) bus.lookup_state <= mem[bus.lookup_set][bus.lookup_way];
    else               bus.lookup_state <= 2'b00;
  end

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int acc_cyc = -1;
  int acc_n = 0;
  int done_cyc = -1;
  int inv_n = 0;
  int lk_q[$];
  int ev_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Samples the current cycle (inputs already applied) then advances to the
  // next falling edge.
  task automatic cyc();
    #1;
    if (bus.flush_req_valid && bus.flush_req_ready) begin
      acc_cyc = cyc_n;
      acc_n++;
      $display("cycle %0d: flush accepted", cyc_n);
    end
    if (bus.lookup_en) lk_q.push_back(int'(bus.lookup_set) * WAYS + int'(bus.lookup_way));
    if (bus.evict_valid && bus.evict_ready) begin
      ev_q.push_back(int'(bus.evict_set) * 4 + int'(bus.evict_way) * 2 + int'(bus.evict_dirty));
      $display("cycle %0d: evict set=%0d way=%0d dirty=%0d", cyc_n,
               bus.evict_set, bus.evict_way, bus.evict_dirty);
    end
    if (bus.inv_en) inv_n++;
    if (bus.flush_done) begin
      done_cyc = cyc_n;
      $display("cycle %0d: flush done", cyc_n);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic wait_done(int budget, string tag);
    int n = 0;
    done_cyc = -1;
    while (done_cyc < 0 && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
  endtask

  task automatic clear_log();
    lk_q.delete();
    ev_q.delete();
    inv_n = 0;
    acc_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic mem_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        mem[s][w] = 2'd0;
  endtask

  function automatic int order_bad();
    int bad = 0;
    for (int i = 0; i < lk_q.size(); i++)
      if (lk_q[i] != i) bad++;
    return bad;
  endfunction

  function automatic int ev_at(int i);
    return (ev_q.size() > i) ? ev_q[i] : -1;
  endfunction

  task automatic start_flush();
    bus.flush_req_valid = 1'b1;
    cyc();
    bus.flush_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush_req_valid = 1'b0;
    bus.stall           = 1'b0;
    bus.reqs_cnt        = 3'd3;
    bus.evict_ready     = 1'b1;
    mem_clear();

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ready",   bus.flush_req_ready, 0);
    check("rst_ongoing", bus.ongoing_flush, 0);
    check("rst_done",    bus.flush_done, 0);
    check("rst_lookup",  bus.lookup_en, 0);
    check("rst_evict",   bus.evict_valid, 0);
    check("rst_inv",     bus.inv_en, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_ready_before_edge", bus.flush_req_ready, 0);
    @(negedge clk);
    #1;
    check("rel_ready_after_edge", bus.flush_req_ready, 1);
    @(negedge clk);

    // ---- all lines INVALID: 26-cycle walk, no evictions ----
    clear_log();
    start_flush();
    #1;
    check("a_ongoing", bus.ongoing_flush, 1);
    check("a_ready_busy", bus.flush_req_ready, 0);
    wait_done(100, "a");
    check("a_latency", done_cyc - acc_cyc + 1, 26);
    check("a_evicts", ev_q.size(), 0);
    check("a_inv", inv_n, 0);
    check("a_lookups", lk_q.size(), 8);
    check("a_order", order_bad(), 0);
    #1;
    check("a_ongoing_after", bus.ongoing_flush, 0);
    check("a_ready_after", bus.flush_req_ready, 1);

    // ---- (1,1) MODIFIED, (3,0) SHARED ----
    mem_clear();
    mem[1][1] = 2'd3;
    mem[3][0] = 2'd1;
    clear_log();
    start_flush();
    wait_done(200, "b");
    check("b_evicts", ev_q.size(), 2);
    check("b_ev0", ev_at(0), 1 * 4 + 1 * 2 + 1);
    check("b_ev1", ev_at(1), 3 * 4 + 0 * 2 + 0);
    check("b_inv", inv_n, 2);
    check("b_latency", done_cyc - acc_cyc + 1, 28);
    check("b_order", order_bad(), 0);

    // ---- evict_ready low 5 cycles on MODIFIED (2,1) ----
    mem_clear();
    mem[2][1] = 2'd3;
    clear_log();
    bus.evict_ready = 1'b0;
    start_flush();
    begin
      int n = 0;
      while (!bus.evict_valid && n < 50) begin
        cyc();
        n++;
      end
      check("c_evict_seen", bus.evict_valid, 1);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      check("c_hold", (bus.evict_valid && bus.evict_set == 2'd2 && bus.evict_way == 1'b1 &&
                       bus.evict_dirty && !bus.inv_en) ? 1 : 0, 1);
      cyc();
    end
    bus.evict_ready = 1'b1;
    #1;
    check("c_inv_on_accept", bus.inv_en, 1);
    wait_done(100, "c");
    check("c_evicts", ev_q.size(), 1);
    check("c_ev0", ev_at(0), 2 * 4 + 1 * 2 + 1);
    check("c_inv", inv_n, 1);

    // ---- no credits in EVICT, then stall in LOOKUP ----
    mem_clear();
    mem[0][1] = 2'd2;
    clear_log();
    bus.reqs_cnt = 3'd0;
    start_flush();                       // now in LOOKUP of line (0,0)
    for (int k = 0; k < 5; k++) cyc();   // now in EVICT of line (0,1)
    for (int k = 0; k < 3; k++) begin
      #1;
      check("d_blocked", (bus.evict_valid || bus.lookup_en || bus.inv_en) ? 1 : 0, 0);
      cyc();
    end
    bus.reqs_cnt = 3'd2;
    #1;
    check("d_evict_resume", bus.evict_valid, 1);
    check("d_evict_target", {30'd0, bus.evict_set} * 2 + {31'd0, bus.evict_way}, 1);
    cyc();                               // eviction accepted, now in NEXT
    bus.stall = 1'b1;
    cyc();                               // now in LOOKUP of line (1,0)
    for (int k = 0; k < 3; k++) begin
      #1;
      check("d_stalled", (bus.lookup_en || bus.evict_valid) ? 1 : 0, 0);
      check("d_stall_pos", int'(bus.lookup_set) * WAYS + int'(bus.lookup_way), 2);
      cyc();
    end
    bus.stall = 1'b0;
    #1;
    check("d_lookup_resume", bus.lookup_en, 1);
    check("d_resume_pos", int'(bus.lookup_set) * WAYS + int'(bus.lookup_way), 2);
    wait_done(100, "d");
    check("d_evicts", ev_q.size(), 1);
    check("d_ev0", ev_at(0), 0 * 4 + 1 * 2 + 0);
    check("d_lookups", lk_q.size(), 8);
    check("d_order", order_bad(), 0);
    check("d_latency", done_cyc - acc_cyc + 1, 33);

    // ---- reset in EVICT mid-flush ----
    mem_clear();
    mem[0][0] = 2'd3;
    clear_log();
    bus.evict_ready = 1'b0;
    start_flush();                       // LOOKUP (0,0)
    cyc();                               // CHECK
    cyc();                               // EVICT
    #1;
    check("e_in_evict", bus.evict_valid, 1);
    rst = 1'b0;
    #1;
    check("e_rst_evict",   bus.evict_valid, 0);
    check("e_rst_lookup",  bus.lookup_en, 0);
    check("e_rst_inv",     bus.inv_en, 0);
    check("e_rst_ongoing", bus.ongoing_flush, 0);
    check("e_rst_done",    bus.flush_done, 0);
    check("e_rst_ready",   bus.flush_req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.evict_ready = 1'b1;
    @(negedge clk);
    #1;
    check("e_ready_release", bus.flush_req_ready, 1);
    clear_log();
    start_flush();
    #1;
    check("e_restart_lookup", bus.lookup_en, 1);
    check("e_restart_pos", int'(bus.lookup_set) * WAYS + int'(bus.lookup_way), 0);
    wait_done(100, "e");
    check("e_evicts", ev_q.size(), 1);
    check("e_ev0", ev_at(0), 0 * 4 + 0 * 2 + 1);

    // ---- request held high through completion ----
    mem_clear();
    clear_log();
    acc_n = 0;
    bus.flush_req_valid = 1'b1;
    cyc();
    wait_done(100, "f1");
    check("f_single_accept", acc_n, 1);
    cyc();
    check("f_second_accept", acc_cyc, done_cyc + 1);
    bus.flush_req_valid = 1'b0;
    wait_done(100, "f2");
    check("f_latency", done_cyc - acc_cyc + 1, 26);
    check("f_accepts", acc_n, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
